jedro_1_dmem: RTL and testbench

Data-memory responder for the jedro_1 core: the memory-side end of the core's data interface (req/gnt/rvalid handshake, byte enables, error flag). It accepts one transaction at a time, commits writes with byte-lane granularity, and returns read data a fixed `LATENCY` cycles after grant. It sits between `jedro_1_top`'s data port and the on-chip SRAM in the SoC and in simulation benches.

---
 rtl/jedro_1_dmem_pkg.sv | 15 +
 rtl/jedro_1_dmem_array.sv | 32 +++
 rtl/jedro_1_dmem.sv | 144 ++++++++++++++
 tb/tb_jedro_1_dmem.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_dmem_pkg.sv
// jedro_1_dmem_pkg: shared widths and FSM state encodings for the data-memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package jedro_1_dmem_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int DMEM_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/jedro_1_dmem_array.sv
// jedro_1_dmem_array: MEM_WORDS x 32 storage, 4-lane byte-write port, registered read port.
// Latency: write commits at the clock edge; read data appears one edge after i_re.
// Backpressure: none; no reset, so it maps onto block RAM.
// Ports: i_clk; write port i_we/i_be/i_waddr/i_wdata; read port i_re/i_raddr -> o_rdata.
module jedro_1_dmem_array
  import jedro_1_dmem_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [DMEM_BE_WIDTH-1:0]     i_be,
  input  logic [$clog2(MEM_WORDS)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic                         i_re,
  input  logic [$clog2(MEM_WORDS)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < DMEM_BE_WIDTH; k++) begin
        if (i_be[k]) r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
    // o_rdata only moves on a read, so it holds the last read word otherwise.
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/jedro_1_dmem.sv
// jedro_1_dmem: memory-side responder for the jedro_1 data port (req/gnt/rvalid, byte enables, err).
// Latency: data_rvalid_o fires LATENCY cycles after the grant cycle; one transaction outstanding.
// Backpressure: data_gnt_o is low while BUSY; the core must hold its request until granted.
// Ports: clk_i, rstn_i (async active-low); request data_req_i/we/be/addr/wdata; data_gnt_o;
//        response data_rvalid_o/data_rdata_o/data_err_o (registered, held between responses).
// Option: define JEDRO_1_DMEM_ERR_EN to flag out-of-range addresses with data_err_o instead of wrapping.
module jedro_1_dmem
  import jedro_1_dmem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     data_req_i,
  output logic                     data_gnt_o,
  input  logic                     data_we_i,
  input  logic [DMEM_BE_WIDTH-1:0] data_be_i,
  input  logic [31:0]              data_addr_i,
  input  logic [DATA_WIDTH-1:0]    data_wdata_i,
  output logic                     data_rvalid_o,
  output logic [DATA_WIDTH-1:0]    data_rdata_o,
  output logic                     data_err_o
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN  = 32'(MEM_WORDS) << 2;

  dmem_state_t       r_state;
  logic [1:0]        r_cnt;
  logic              r_we;
  logic              r_err;
  logic [IDX_W-1:0]  r_idx;
  logic              r_rvalid;
  logic              r_err_o;
  logic              r_zero;

  logic              w_acc;
  logic [31:0]       w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_unused;
  logic              w_fire;
  logic              w_fire_we;
  logic              w_fire_err;
  logic [IDX_W-1:0]  w_fire_idx;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign data_gnt_o = data_req_i && rstn_i && (r_state == DMEM_IDLE || r_state == DMEM_RESP);
  assign w_acc      = data_gnt_o;

  assign w_off = data_addr_i - BASE_ADDR;
  assign w_idx = w_off[IDX_W+1:2];

`ifdef JEDRO_1_DMEM_ERR_EN
  // Unsigned compare also catches addresses below BASE_ADDR (they wrap to huge offsets).
  assign w_err    = (w_off >= SPAN);
  assign w_unused = ^w_off[1:0];
`else
  assign w_err    = 1'b0;
  assign w_unused = ^{w_off[31:IDX_W+2], w_off[1:0]};
`endif

  // w_fire marks the edge at which the response is produced (edge ending cycle N+LATENCY-1).
  // With LATENCY 1 that is the grant edge itself, so the fields come straight off the inputs.
  always_comb begin
    if (LATENCY == 1) begin
      w_fire     = w_acc;
      w_fire_we  = data_we_i;
      w_fire_err = w_err;
      w_fire_idx = w_idx;
    end else begin
      w_fire     = (r_state == DMEM_BUSY) && (r_cnt == 2'd0);
      w_fire_we  = r_we;
      w_fire_err = r_err;
      w_fire_idx = r_idx;
    end
  end

  assign w_mem_we = w_acc && data_we_i && !w_err;
  assign w_mem_re = w_fire && !w_fire_we && !w_fire_err;

  jedro_1_dmem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .i_clk   (clk_i),
    .i_we    (w_mem_we),
    .i_be    (data_be_i),
    .i_waddr (w_idx),
    .i_wdata (data_wdata_i),
    .i_re    (w_mem_re),
    .i_raddr (w_fire_idx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= DMEM_IDLE;
      r_cnt    <= 2'd0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_rvalid <= 1'b0;
      r_err_o  <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_rvalid <= w_fire;
      if (w_fire) begin
        // Write and error responses return zero data; reads show the array word.
        r_zero  <= w_fire_we | w_fire_err;
        r_err_o <= w_fire_err;
      end
      case (r_state)
        DMEM_BUSY: begin
          if (r_cnt == 2'd0) r_state <= DMEM_RESP;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        default: begin
          if (w_acc) begin
            r_we  <= data_we_i;
            r_err <= w_err;
            r_idx <= w_idx;
            if (LATENCY == 1) begin
              r_state <= DMEM_RESP;
            end else begin
              r_state <= DMEM_BUSY;
              r_cnt   <= 2'(LATENCY - 2);
            end
          end else begin
            r_state <= DMEM_IDLE;
          end
        end
      endcase
    end
  end

  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_zero ? '0 : w_mem_rdata;
  assign data_err_o    = r_err_o;

endmodule

// File: tb/tb_jedro_1_dmem.sv
// tb_jedro_1_dmem: directed checks of jedro_1_dmem at LATENCY 1, 3 and 4.
// Unit 0: LATENCY=1, unit 1: LATENCY=3, unit 2: LATENCY=4; all MEM_WORDS=1024, base 0.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_jedro_1_dmem;

  logic        clk;
  logic        rstn  [3];
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        gnt   [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
  logic        err   [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int lat_of [3] = '{1, 3, 4};

  jedro_1_dmem #(.MEM_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
    .clk_i(clk), .rstn_i(rstn[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_we_i(we[0]), .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]));

  jedro_1_dmem #(.MEM_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_l3 (
    .clk_i(clk), .rstn_i(rstn[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_we_i(we[1]), .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]));

  jedro_1_dmem #(.MEM_WORDS(1024), .LATENCY(4), .BASE_ADDR(32'h0)) u_l4 (
    .clk_i(clk), .rstn_i(rstn[2]), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_we_i(we[2]), .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
    .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] b2w(input logic b);
    return {31'd0, b};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One complete transaction on unit u: waits for grant, drops req, waits for rvalid
  // and checks the grant-to-rvalid distance against that unit's LATENCY.
  task automatic xact(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] rd, output logic e);
    int t;
    @(posedge clk); #1;
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
    t = 0;
    @(negedge clk);
    while (!gnt[u] && t < 20) begin @(negedge clk); t++; end
    check_vec("gnt_wait", t, 0);
    @(posedge clk); #1;
    req[u] = 1'b0; we[u] = 1'b0;
    t = 1;
    @(negedge clk);
    while (!rvalid[u] && t < 20) begin @(negedge clk); t++; end
    check_vec("latency", t, lat_of[u]);
    rd = rdata[u];
    e  = err[u];
  endtask

  logic [31:0] rd;
  logic        e;
  int          base;
  int          n;
  int          gq[$];
  int          vq[$];

  initial begin
    for (int u = 0; u < 3; u++) begin
      rstn[u] = 1'b0; req[u] = 1'b0; we[u] = 1'b0; be[u] = 4'h0; addr[u] = '0; wdata[u] = '0;
    end
    req[0] = 1'b1;

    // Reset state: no grant even with req high, outputs at reset values.
    @(negedge clk);
    check_vec("rst_gnt", b2w(gnt[0]), 32'd0);
    check_vec("rst_rvalid", b2w(rvalid[0]), 32'd0);
    check_vec("rst_rdata", rdata[0], 32'h0);
    check_vec("rst_err", b2w(err[0]), 32'd0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) rstn[u] = 1'b1;

    // LATENCY 1: write then read in back-to-back cycles with req held.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEADBEEF; be[0] = 4'hF;
    @(negedge clk);
    check_vec("b2b_c0_gnt", b2w(gnt[0]), 32'd1);
    check_vec("b2b_c0_rvalid", b2w(rvalid[0]), 32'd0);
    @(posedge clk); #1;
    we[0] = 1'b0;
    @(negedge clk);
    check_vec("b2b_c1_gnt", b2w(gnt[0]), 32'd1);
    check_vec("b2b_c1_rvalid", b2w(rvalid[0]), 32'd1);
    check_vec("b2b_c1_wr_rdata", rdata[0], 32'h0);
    check_vec("b2b_c1_err", b2w(err[0]), 32'd0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check_vec("b2b_c2_rvalid", b2w(rvalid[0]), 32'd1);
    check_vec("b2b_c2_rdata", rdata[0], 32'hDEADBEEF);
    check_vec("b2b_c2_err", b2w(err[0]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_vec("b2b_c3_rvalid", b2w(rvalid[0]), 32'd0);
    check_vec("b2b_c3_hold", rdata[0], 32'hDEADBEEF);

    // Byte lanes: lanes 0 and 2 replaced.
    xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, e);
    xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e);
    check_vec("lane_wr_rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, e);
    check_vec("lane_rd", rd, 32'h11BB33DD);

    // be = 0 write: normal response, word untouched.
    xact(0, 1'b1, 32'h30, 32'h12345678, 4'hF, rd, e);
    xact(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, rd, e);
    check_vec("be0_err", b2w(e), 32'd0);
    check_vec("be0_rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h30, 32'h0, 4'hF, rd, e);
    check_vec("be0_rd", rd, 32'h12345678);

    // Address one past the top of memory.
    xact(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, e);
    xact(0, 1'b1, 32'h1000, 32'h5, 4'hF, rd, e);
`ifdef JEDRO_1_DMEM_ERR_EN
    check_vec("oor_err", b2w(e), 32'd1);
    check_vec("oor_rdata", rd, 32'h0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, e);
    check_vec("oor_word0", rd, 32'hA5A5A5A5);
`else
    check_vec("oor_err", b2w(e), 32'd0);
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, e);
    check_vec("oor_word0", rd, 32'h5);
`endif
    check_vec("oor_rd_err", b2w(e), 32'd0);

    // LATENCY 3: four reads with req held continuously.
    xact(1, 1'b1, 32'h40, 32'h0BADCAFE, 4'hF, rd, e);
    @(posedge clk); #1;
    base = cyc_n;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40; be[1] = 4'hF;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (gnt[1]) gq.push_back(cyc_n - base);
      if (rvalid[1]) begin
        vq.push_back(cyc_n - base);
        check_vec("l3_rdata", rdata[1], 32'h0BADCAFE);
      end
      @(posedge clk); #1;
      if (gq.size() == 4) req[1] = 1'b0;
    end
    req[1] = 1'b0;
    check_vec("l3_gnt_count", gq.size(), 4);
    check_vec("l3_rvalid_count", vq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_vec("l3_gnt_cycle", (i < gq.size()) ? gq[i] : -1, 3 * i);
      check_vec("l3_rvalid_cycle", (i < vq.size()) ? vq[i] : -1, 3 * i + 3);
    end

    // LATENCY 4: reset at N+2 after a read grant drops the response.
    xact(2, 1'b1, 32'h50, 32'hCAFEF00D, 4'hF, rd, e);
    check_vec("l4_wr_err", b2w(e), 32'd0);
    xact(2, 1'b0, 32'h50, 32'h0, 4'hF, rd, e);
    check_vec("l4_rd", rd, 32'hCAFEF00D);
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h50;
    @(negedge clk);
    check_vec("mid_rst_gnt", b2w(gnt[2]), 32'd1);
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    rstn[2] = 1'b0; req[2] = 1'b1;
    @(negedge clk);
    check_vec("mid_rst_gnt_low", b2w(gnt[2]), 32'd0);
    check_vec("mid_rst_rvalid", b2w(rvalid[2]), 32'd0);
    check_vec("mid_rst_rdata", rdata[2], 32'h0);
    req[2] = 1'b0;
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid[2]) n++;
    end
    check_vec("mid_rst_no_rvalid", n, 0);
    xact(2, 1'b0, 32'h50, 32'h0, 4'hF, rd, e);
    check_vec("post_rst_rd", rd, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
